// File: rtl/ysyx_220053_pkg.sv
// ysyx_220053_pkg: shared constants and FSM state type for the instruction fetch unit
package ysyx_220053_pkg;
    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_FULL} state_e;
endpackage

// File: rtl/ysyx_220053_ifu.sv
// ysyx_220053_ifu: single-outstanding instruction fetch unit with redirect and response drop
module ysyx_220053_ifu
    import ysyx_220053_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o,
    input  logic            ready_i
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pco_q, pco_d;
    logic [31:0]     instr_q, instr_d;
    logic            hs;

    assign hs             = state_q == S_REQ && imem_req_ready;
    assign imem_req_valid = !rst && state_q == S_REQ;
    assign imem_req_addr  = pc_q;
    assign valid_o        = !rst && state_q == S_FULL;
    assign instr_o        = instr_q;
    assign pc_o           = pco_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pco_d   = pco_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~64'd3;
            state_d = state_q == S_REQ  ? (hs ? S_DROP : S_REQ) :
                      state_q == S_WAIT ? (imem_resp_valid ? S_REQ : S_DROP) :
                      state_q == S_DROP ? S_DROP : S_REQ;
        end else begin
            if (hs)
                state_d = S_WAIT;
            if (state_q == S_WAIT && imem_resp_valid) begin
                state_d = S_FULL;
                instr_d = imem_resp_data;
                pco_d   = pc_q;
            end
            if (state_q == S_DROP && imem_resp_valid)
                state_d = S_REQ;
            if (state_q == S_FULL && ready_i) begin
                state_d = S_REQ;
                pc_d    = pc_q + 64'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            pco_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
        end
    end
endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// tb_ysyx_220053_ifu: directed bench with a flag-based transaction model checked every cycle
module tb_ysyx_220053_ifu;
    logic        clk = 0;
    logic        rst = 1;
    logic        imem_req_valid, imem_req_ready = 0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 0;
    logic [31:0] imem_resp_data = 0;
    logic        redirect_valid = 0;
    logic [63:0] redirect_pc = 0;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        valid_o, ready_i = 0;

    int checks = 0, errors = 0;

    ysyx_220053_ifu dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_o(instr_o), .pc_o(pc_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return a == 64'h8000_0000 ? 32'h0010_0093 : a[31:0] ^ 32'h1357_0013;
    endfunction

    // memory: answers an accepted request lat cycles later; spur injects a stray response
    int          cnt = 0, lat = 1;
    logic [63:0] maddr = 0;
    logic        spur = 0;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            cnt = 0;
            imem_resp_valid = 0;
        end else begin
            imem_resp_valid = spur || cnt == 1;
            imem_resp_data  = spur ? 32'hDEAD_BEEF : mem(maddr);
            if (cnt > 0) cnt--;
            if (imem_req_valid && imem_req_ready) begin
                cnt   = lat;
                maddr = imem_req_addr;
            end
        end
    end

    // model: outstanding / discard-pending / holding flags instead of a state register
    logic [63:0] m_pc = 64'h8000_0000, m_pco = 0;
    logic [31:0] m_instr = 32'h13;
    logic        m_out = 0, m_disc = 0, m_have = 0;

    task automatic model_update();
        logic want;
        want = !m_out && !m_have;
        if (rst) begin
            m_pc = 64'h8000_0000; m_out = 0; m_disc = 0; m_have = 0;
            m_instr = 32'h13; m_pco = 0;
        end else if (redirect_valid) begin
            m_pc   = {redirect_pc[63:2], 2'b00};
            m_have = 0;
            if (want && imem_req_ready) begin
                m_out = 1; m_disc = 1;
            end else if (m_out && !m_disc) begin
                if (imem_resp_valid) m_out = 0;
                else m_disc = 1;
            end
        end else if (want && imem_req_ready) begin
            m_out = 1;
        end else if (m_out && imem_resp_valid) begin
            if (m_disc) m_disc = 0;
            else begin
                m_have = 1; m_instr = imem_resp_data; m_pco = m_pc;
            end
            m_out = 0;
        end else if (m_have && ready_i) begin
            m_pc   = m_pc + 64'd4;
            m_have = 0;
        end
    endtask

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic er;
        @(negedge clk);
        model_update();
        er = !rst && !m_out && !m_have;
        cmp("req_valid", {63'd0, imem_req_valid}, {63'd0, er});
        cmp("valid_o", {63'd0, valid_o}, {63'd0, !rst && m_have});
        if (er) cmp("req_addr", imem_req_addr, m_pc);
        cmp("instr_o", {32'd0, instr_o}, {32'd0, m_instr});
        cmp("pc_o", pc_o, m_pco);
    endtask

    initial begin
        tick(); tick();
        cmp("rst_valid", {63'd0, valid_o}, 64'd0);
        cmp("rst_instr", {32'd0, instr_o}, 64'h13);
        cmp("rst_pc_o", pc_o, 64'd0);
        rst = 0; imem_req_ready = 1; ready_i = 1; lat = 1;
        #1;
        cmp("first_addr", imem_req_addr, 64'h8000_0000);
        cmp("first_req", {63'd0, imem_req_valid}, 64'd1);
        tick(); tick();
        cmp("first_valid", {63'd0, valid_o}, 64'd1);
        cmp("first_instr", {32'd0, instr_o}, 64'h0010_0093);
        cmp("first_pc", pc_o, 64'h8000_0000);
        ready_i = 0;
        repeat (5) tick();
        cmp("hold_instr", {32'd0, instr_o}, 64'h0010_0093);
        cmp("hold_pc", pc_o, 64'h8000_0000);
        ready_i = 1;
        tick();
        cmp("next_addr", imem_req_addr, 64'h8000_0004);
        lat = 3;
        tick();
        redirect_valid = 1; redirect_pc = 64'h8000_0103;
        tick();
        redirect_valid = 0;
        tick(); tick();
        cmp("wait_redir_addr", imem_req_addr, 64'h8000_0100);
        cmp("wait_redir_valid", {63'd0, valid_o}, 64'd0);
        lat = 1;
        tick(); tick();
        cmp("b_pc", pc_o, 64'h8000_0100);
        cmp("b_instr", {32'd0, instr_o}, 64'h9357_0113);
        redirect_valid = 1; redirect_pc = 64'h8000_1000;
        tick();
        redirect_valid = 0;
        cmp("full_redir_addr", imem_req_addr, 64'h8000_1000);
        tick(); tick();
        cmp("c_pc", pc_o, 64'h8000_1000);
        tick();
        cmp("d_addr", imem_req_addr, 64'h8000_1004);
        redirect_valid = 1; redirect_pc = 64'h8000_2000;
        tick();
        redirect_valid = 0;
        tick(); tick();
        cmp("drop_addr", imem_req_addr, 64'h8000_2000);
        cmp("drop_valid", {63'd0, valid_o}, 64'd0);
        tick(); tick();
        cmp("d_pc", pc_o, 64'h8000_2000);
        cmp("d_instr", {32'd0, instr_o}, 64'h9357_2013);
        tick(); tick();
        redirect_valid = 1; redirect_pc = 64'h8000_3000;
        tick();
        redirect_valid = 0;
        cmp("wait_resp_redir_addr", imem_req_addr, 64'h8000_3000);
        tick(); tick();
        imem_req_ready = 0;
        tick();
        spur = 1;
        tick();
        spur = 0; imem_req_ready = 1;
        tick(); tick();
        cmp("spur_instr", {32'd0, instr_o}, 64'h9357_3017);
        ready_i = 0; spur = 1;
        tick();
        spur = 0; ready_i = 1; lat = 3;
        tick(); tick();
        rst = 1;
        tick();
        cmp("mid_rst_valid", {63'd0, valid_o}, 64'd0);
        rst = 0; imem_req_ready = 0; spur = 1;
        #1;
        cmp("post_rst_addr", imem_req_addr, 64'h8000_0000);
        tick();
        cmp("late_resp_instr", {32'd0, instr_o}, 64'h13);
        spur = 0; imem_req_ready = 1; lat = 1;
        tick(); tick();
        cmp("g_pc", pc_o, 64'h8000_0000);
        redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect_valid = 0;
        cmp("top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); tick(); tick();
        cmp("wrap_addr", imem_req_addr, 64'd0);
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
